// File: rtl/control_envio_pkg.sv
// rtl/control_envio_pkg.sv - shared state encoding, frame width and default timing for control_envio
package control_envio_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_BIT_LO  = 3'd2;
    localparam logic [2:0] ST_BIT_HI  = 3'd3;
    localparam logic [2:0] ST_STOP_LO = 3'd4;
    localparam logic [2:0] ST_STOP_HI = 3'd5;

    localparam int DIV_DEFAULT     = 4;
    localparam int NB_DEFAULT      = 3;
    localparam int FRAME_W_DEFAULT = NB_DEFAULT + 1;

    // Frame carries a one-bit source id ahead of the NB-bit data word.
    function automatic int frame_width(input int nb);
        return nb + 1;
    endfunction

endpackage

// File: rtl/control_envio_divisor_scl.sv
// rtl/control_envio_divisor_scl.sv - per-state phase counter, ticks on the last cycle of a phase
module divisor_scl #(
    parameter int DIV = 4
) (
    input  logic clk1,
    input  logic reset1,
    input  logic load,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/control_envio.sv
// rtl/control_envio.sv - round-robin two-source serial frame sender with start/stop conditions
module control_envio
    import control_envio_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int NB  = NB_DEFAULT
) (
    input  logic          clk1,
    input  logic          reset1,
    input  logic          req0,
    input  logic [NB-1:0] data0,
    input  logic          req1,
    input  logic [NB-1:0] data1,
    output logic          ack0,
    output logic          ack1,
    output logic          busy,
    output logic          done,
    output logic          sda,
    output logic          scl
);

    localparam int FW = frame_width(NB);
    localparam int IW = (NB < 1) ? 1 : $clog2(NB + 1);

    logic [2:0]    state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          prio_q, prio_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sda_q, sda_d;
    logic          scl_q, scl_d;
    logic          load;
    logic          tick;
    logic          grant;
    logic          pick1;

    divisor_scl #(.DIV(DIV)) u_divisor_scl (
        .clk1   (clk1),
        .reset1 (reset1),
        .load   (load),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        prio_d  = prio_q;
        load    = 1'b0;
        grant   = 1'b0;
        pick1   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // prio_q set means source 1 wins a tie; a lone request always wins
                    pick1   = req1 && (!req0 || prio_q);
                    grant   = 1'b1;
                    frame_d = pick1 ? {1'b1, data1} : {1'b0, data0};
                    prio_d  = !pick1;
                    idx_d   = '0;
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_BIT_LO;
                    load    = 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (tick) begin
                    state_d = ST_BIT_HI;
                    load    = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (tick) begin
                    load = 1'b1;
                    if (idx_q == IW'(NB)) begin
                        state_d = ST_STOP_LO;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        frame_d = {frame_q[FW-2:0], 1'b0};
                        state_d = ST_BIT_LO;
                    end
                end
            end
            ST_STOP_LO: begin
                if (tick) begin
                    state_d = ST_STOP_HI;
                    load    = 1'b1;
                end
            end
            ST_STOP_HI: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line levels are derived from the next state so every output is a flop
    always_comb begin
        ack0_d = grant && !pick1;
        ack1_d = grant && pick1;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP_HI) && tick;
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        case (state_d)
            ST_START:   begin scl_d = 1'b1; sda_d = 1'b0;          end
            ST_BIT_LO:  begin scl_d = 1'b0; sda_d = frame_d[FW-1]; end
            ST_BIT_HI:  begin scl_d = 1'b1; sda_d = sda_q;         end
            ST_STOP_LO: begin scl_d = 1'b0; sda_d = 1'b0;          end
            ST_STOP_HI: begin scl_d = 1'b1; sda_d = 1'b0;          end
            default:    begin scl_d = 1'b1; sda_d = 1'b1;          end
        endcase
    end

    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            prio_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            prio_q  <= prio_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sda_q   <= sda_d;
            scl_q   <= scl_d;
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sda  = sda_q;
    assign scl  = scl_q;

endmodule

// File: tb/tb_control_envio.sv
// tb/tb_control_envio.sv - directed self-checking bench for control_envio
module tb_control_envio;

    logic       clk1 = 1'b0;
    logic       reset1, r1_reset;
    logic       req0, req1, r1_req0;
    logic [2:0] data0, data1;
    logic       sel;

    logic d4_ack0, d4_ack1, d4_busy, d4_done, d4_sda, d4_scl;
    logic d1_ack0, d1_ack1, d1_busy, d1_done, d1_sda, d1_scl;
    logic o_ack0, o_ack1, o_busy, o_done, o_sda, o_scl;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk1 = ~clk1;

    control_envio #(.DIV(4), .NB(3)) dut4 (
        .clk1(clk1), .reset1(reset1), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(d4_ack0), .ack1(d4_ack1), .busy(d4_busy), .done(d4_done), .sda(d4_sda), .scl(d4_scl)
    );

    control_envio #(.DIV(1), .NB(3)) dut1 (
        .clk1(clk1), .reset1(r1_reset), .req0(r1_req0), .data0(3'b000), .req1(1'b0), .data1(3'b000),
        .ack0(d1_ack0), .ack1(d1_ack1), .busy(d1_busy), .done(d1_done), .sda(d1_sda), .scl(d1_scl)
    );

    assign o_ack0 = sel ? d1_ack0 : d4_ack0;
    assign o_ack1 = sel ? d1_ack1 : d4_ack1;
    assign o_busy = sel ? d1_busy : d4_busy;
    assign o_done = sel ? d1_done : d4_done;
    assign o_sda  = sel ? d1_sda  : d4_sda;
    assign o_scl  = sel ? d1_scl  : d4_scl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk1);
        reset1 = 1'b0;
        #1;
        chk("reset_outputs", {d4_scl, d4_sda, d4_ack0, d4_ack1, d4_done, d4_busy}, 6'b110000);
        repeat (2) @(negedge clk1);
        reset1 = 1'b1;
    endtask

    // act: [0] drop req0, [1] drop req1, [2] raise req0 (all right after ack), [3] flip data0 one cycle later
    task automatic watch_frame(input string tag, input logic exp_src, input logic [3:0] exp_bits,
                               input int exp_len, input int exp_wait, input logic [3:0] act);
        int w, n, nb, glitch, busy_ack, done_n;
        logic [4:0] bits;
        logic ps, pd;
        w = 0;
        do begin
            @(negedge clk1);
            w++;
        end while (!(o_ack0 || o_ack1) && w < 200);
        chk({tag, "_ack_seen"}, 32'(w < 200), 1);
        if (exp_wait > 0) chk({tag, "_idle_gap"}, w, exp_wait);
        chk({tag, "_ack_src"}, {o_ack1, o_ack0}, exp_src ? 2'b10 : 2'b01);
        chk({tag, "_start_cond"}, {o_scl, o_sda, o_busy}, 3'b101);
        if (act[0]) begin req0 = 1'b0; r1_req0 = 1'b0; end
        if (act[1]) req1 = 1'b0;
        if (act[2]) req0 = 1'b1;
        ps = o_scl; pd = o_sda; n = 0; nb = 0; glitch = 0; busy_ack = 0; done_n = -1; bits = '0;
        while (done_n < 0 && n < exp_len + 8) begin
            @(negedge clk1);
            n++;
            if (n == 1 && act[3]) data0 = data0 ^ 3'b111;
            if (o_done) begin
                done_n = n;
            end else begin
                if (o_ack0 || o_ack1) busy_ack++;
                if (o_scl && !ps) begin bits = {bits[3:0], o_sda}; nb++; end
                if (o_scl && ps && (o_sda !== pd)) glitch++;
                ps = o_scl; pd = o_sda;
            end
        end
        chk({tag, "_done_cycle"}, done_n, exp_len);
        // the last scl rise is STOP_HI, which must show sda low
        chk({tag, "_bits"}, bits, {exp_bits, 1'b0});
        chk({tag, "_nrises"}, nb, 5);
        chk({tag, "_no_ack_busy"}, busy_ack, 0);
        chk({tag, "_sda_stable"}, glitch, 0);
        chk({tag, "_stop_cond"}, {ps, pd, o_scl, o_sda, o_busy}, 5'b10110);
    endtask

    initial begin
        int w;
        int dn;
        sel = 1'b0; reset1 = 1'b1; r1_reset = 1'b0; r1_req0 = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 3'b000; data1 = 3'b000;

        // scenario 1
        req0 = 1'b1; data0 = 3'b101;
        do_reset();
        watch_frame("s1", 1'b0, 4'b0101, 44, 1, 4'b0001);

        // scenario 2
        req0 = 1'b1; req1 = 1'b1; data1 = 3'b011;
        do_reset();
        watch_frame("s2a", 1'b0, 4'b0101, 44, 1, 4'b0001);
        watch_frame("s2b", 1'b1, 4'b1011, 44, 1, 4'b0010);

        // scenario 3
        req1 = 1'b1;
        watch_frame("s3a", 1'b1, 4'b1011, 44, 1, 4'b0100);
        watch_frame("s3b", 1'b0, 4'b0101, 44, 1, 4'b0001);
        watch_frame("s3c", 1'b1, 4'b1011, 44, 1, 4'b0010);

        // scenario 4: reset during BIT_HI of bit 2
        req0 = 1'b1; data0 = 3'b101;
        w = 0;
        do begin
            @(negedge clk1);
            w++;
        end while (!d4_ack0 && w < 200);
        chk("s4_ack_seen", 32'(w < 200), 1);
        repeat (25) @(negedge clk1);
        chk("s4_in_bit_hi", {d4_scl, d4_busy}, 2'b11);
        reset1 = 1'b0;
        #1;
        chk("s4_async_reset", {d4_scl, d4_sda, d4_busy, d4_ack0, d4_done}, 5'b11000);
        dn = 0;
        repeat (3) begin
            @(negedge clk1);
            if (d4_done) dn++;
        end
        chk("s4_no_done", dn, 0);
        reset1 = 1'b1;
        watch_frame("s4", 1'b0, 4'b0101, 44, 1, 4'b0001);

        // scenario 5: DIV=1 instance
        sel = 1'b1;
        @(negedge clk1);
        r1_reset = 1'b1;
        r1_req0 = 1'b1;
        watch_frame("s5", 1'b0, 4'b0000, 11, 1, 4'b0001);
        sel = 1'b0;

        // scenario 6: data0 altered after grant
        @(negedge clk1);
        req0 = 1'b1; data0 = 3'b101;
        watch_frame("s6", 1'b0, 4'b0101, 44, 1, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
